// File: rtl/axis_filter_arbiter.sv
// Shares one streaming filter between two AXI-Stream requesters. Whole frames are
// granted round-robin, and a tag FIFO routes each filtered beat back to its owner.
module axis_filter_arbiter #(
  parameter int unsigned W         = 200,
  parameter int unsigned TAG_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rstn,

  input  logic         s0_valid,
  output logic         s0_ready,
  input  logic         s0_last,
  input  logic [W-1:0] s0_data,

  input  logic         s1_valid,
  output logic         s1_ready,
  input  logic         s1_last,
  input  logic [W-1:0] s1_data,

  output logic         f_s_valid,
  input  logic         f_s_ready,
  output logic [W-1:0] f_s_data,

  input  logic         f_m_valid,
  output logic         f_m_ready,
  input  logic [W-1:0] f_m_data,

  output logic         m0_valid,
  input  logic         m0_ready,
  output logic         m0_last,
  output logic [W-1:0] m0_data,

  output logic         m1_valid,
  input  logic         m1_ready,
  output logic         m1_last,
  output logic [W-1:0] m1_data,

  output logic [1:0]   grant,
  output logic         tag_err
);

  localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
  localparam int unsigned CNT_W = $clog2(TAG_DEPTH) + 1;

  // The state encoding doubles as the one-hot grant, so grant comes straight from a flop.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_e;

  typedef struct packed {
    logic id;
    logic last;
  } tag_t;

  state_e           state_q, state_d;
  logic             rr_last_q, rr_last_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tag_err_q, tag_err_d;
  tag_t             tag_mem [TAG_DEPTH];

  logic tag_full;
  logic tag_empty;
  logic push;
  logic pop;
  tag_t push_tag;
  tag_t head_tag;

  assign tag_full  = (count_q == CNT_W'(TAG_DEPTH));
  assign tag_empty = (count_q == '0);
  assign head_tag  = tag_mem[rd_ptr_q];

  // Input side: the owner's stream passes straight through to the filter.
  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    s0_ready  = 1'b0;
    s1_ready  = 1'b0;
    f_s_valid = 1'b0;
    f_s_data  = s0_data;
    push_tag  = '{id: 1'b0, last: s0_last};
    unique case (state_q)
      GRANT0: begin
        f_s_valid = s0_valid & ~tag_full;
        s0_ready  = f_s_ready & ~tag_full;
      end
      GRANT1: begin
        f_s_valid = s1_valid & ~tag_full;
        s1_ready  = f_s_ready & ~tag_full;
        f_s_data  = s1_data;
        push_tag  = '{id: 1'b1, last: s1_last};
      end
      default: ;
    endcase
  end

  assign push = f_s_valid & f_s_ready;

  // Grant is held for a whole frame; the requester not served last wins a tie.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    unique case (state_q)
      IDLE: begin
        if (s0_valid && s1_valid) state_d = rr_last_q ? GRANT0 : GRANT1;
        else if (s0_valid)        state_d = GRANT0;
        else if (s1_valid)        state_d = GRANT1;
      end
      GRANT0: begin
        if (push && push_tag.last) begin
          state_d   = IDLE;
          rr_last_d = 1'b0;
        end
      end
      GRANT1: begin
        if (push && push_tag.last) begin
          state_d   = IDLE;
          rr_last_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output side: the head tag steers the filtered beat; an empty FIFO blocks everything.
  always_comb begin
    m0_valid  = f_m_valid & ~tag_empty & ~head_tag.id;
    m1_valid  = f_m_valid & ~tag_empty &  head_tag.id;
    f_m_ready = ~tag_empty & (head_tag.id ? m1_ready : m0_ready);
    m0_data   = f_m_data;
    m1_data   = f_m_data;
    m0_last   = head_tag.last;
    m1_last   = head_tag.last;
  end

  assign pop = f_m_valid & f_m_ready;

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    tag_err_d = tag_err_q | (f_m_valid & tag_empty);
  end

  // NOTE: sequential state is written with non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tag_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tag_err_q <= tag_err_d;
    end
  end

  // NOTE: tag storage is not reset; an entry is only read after count_q says it was written.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_q] <= push_tag;
  end

  assign grant   = state_q;
  assign tag_err = tag_err_q;

endmodule
